msk_and_hpc1_pipe: RTL and testbench

- Vectorised, flow-controlled HPC1 masked AND: NBITS independent lanes, D shares each.
- Each lane performs an SNI refresh of one operand, then a DOM multiplication.
- Wraps the gadget in a 3-stage valid/ready pipeline with stall support and a randomness-valid handshake, so it can sit directly in datapaths fed by a PRNG that may starve.
- Replaces fixed-latency, always-enabled AND gadgets where back-pressure exists.

---
 rtl/msk_hpc1_pkg.sv | 34 +++
 rtl/msk_hpc1_lane.sv | 86 ++++++++
 rtl/msk_and_hpc1_pipe.sv | 78 +++++++
 tb/tb_msk_and_hpc1_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/msk_hpc1_pkg.sv
// Shared sizing and indexing helpers for the HPC1 masked AND gadget.
// Randomness per lane = ISW refresh bits followed by DOM bits.
package msk_hpc1_pkg;

  function automatic int unsigned ref_rnd(input int unsigned d);
    return d * (d - 1) / 2;
  endfunction

  function automatic int unsigned dom_rnd(input int unsigned d);
    return d * (d - 1) / 2;
  endfunction

  function automatic int unsigned hpc1_rnd(input int unsigned d);
    return ref_rnd(d) + dom_rnd(d);
  endfunction

  // Index of the random bit shared by domain pair (i, j), i < j, in row-major order.
  function automatic int unsigned pair_idx(input int unsigned d, input int unsigned i,
                                           input int unsigned j);
    int unsigned p;
    p = 0;
    for (int unsigned k = 0; k < i; k++) p += d - 1 - k;
    return p + (j - i - 1);
  endfunction

  function automatic int unsigned share_lo(input int unsigned lane, input int unsigned d);
    return lane * d;
  endfunction

  function automatic int unsigned rnd_lo(input int unsigned lane, input int unsigned d);
    return lane * hpc1_rnd(d);
  endfunction

endpackage

// File: rtl/msk_hpc1_lane.sv
// One HPC1 lane: ISW refresh of one operand, then DOM multiplication over
// three registered stages, each gated by its own load enable.
module msk_hpc1_lane
  import msk_hpc1_pkg::*;
#(
  parameter int unsigned D       = 2,
  parameter bit          REF_SEL = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ld1_i,
  input  logic                   ld2_i,
  input  logic                   ld3_i,
  input  logic [D-1:0]           a_i,
  input  logic [D-1:0]           b_i,
  input  logic [hpc1_rnd(D)-1:0] rnd_i,
  output logic [D-1:0]           out_o
);

  localparam int unsigned REF_RND = ref_rnd(D);
  localparam int unsigned DOM_RND = dom_rnd(D);

  logic [REF_RND-1:0] r_ref;
  logic [DOM_RND-1:0] r_dom;
  logic [D-1:0]       op_ref;
  logic [D-1:0]       a1_d, b1_d, a1_q, b1_q;
  logic [DOM_RND-1:0] rd1_q;
  logic [D*D-1:0]     t2_d, t2_q;
  logic [D-1:0]       o3_d, o3_q;

  assign r_ref = rnd_i[REF_RND-1:0];
  assign r_dom = rnd_i[REF_RND +: DOM_RND];

  always_comb begin
    op_ref = REF_SEL ? a_i : b_i;
    for (int unsigned i = 0; i < D; i++) begin
      for (int unsigned j = i + 1; j < D; j++) begin
        op_ref[i] = op_ref[i] ^ r_ref[pair_idx(D, i, j)];
        op_ref[j] = op_ref[j] ^ r_ref[pair_idx(D, i, j)];
      end
    end
    a1_d = REF_SEL ? op_ref : a_i;
    b1_d = REF_SEL ? b_i : op_ref;
  end

  // Term (i, j) lands in row i; rows become output domains in stage 3.
  always_comb begin
    t2_d = '0;
    for (int unsigned i = 0; i < D; i++) begin
      for (int unsigned j = 0; j < D; j++) begin
        if (i == j)
          t2_d[i*D+j] = a1_q[i] & b1_q[j];
        else if (i < j)
          t2_d[i*D+j] = (a1_q[i] & b1_q[j]) ^ rd1_q[pair_idx(D, i, j)];
        else
          t2_d[i*D+j] = (a1_q[i] & b1_q[j]) ^ rd1_q[pair_idx(D, j, i)];
      end
    end
  end

  always_comb begin
    o3_d = '0;
    for (int unsigned i = 0; i < D; i++) o3_d[i] = ^t2_q[i*D +: D];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a1_q  <= '0;
      b1_q  <= '0;
      rd1_q <= '0;
      t2_q  <= '0;
      o3_q  <= '0;
    end else begin
      if (ld1_i) begin
        a1_q  <= a1_d;
        b1_q  <= b1_d;
        rd1_q <= r_dom;
      end
      if (ld2_i) t2_q <= t2_d;
      if (ld3_i) o3_q <= o3_d;
    end
  end

  assign out_o = o3_q;

endmodule

// File: rtl/msk_and_hpc1_pipe.sv
// Vectorised HPC1 masked AND with a 3-stage valid/ready pipeline and a
// randomness-valid handshake; share registers only load behind a valid.
module msk_and_hpc1_pipe
  import msk_hpc1_pkg::*;
#(
  parameter int unsigned D       = 2,
  parameter int unsigned NBITS   = 1,
  parameter bit          REF_SEL = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [D*NBITS-1:0]           ina,
  input  logic [D*NBITS-1:0]           inb,
  input  logic                         rnd_valid,
  output logic                         rnd_ready,
  input  logic [NBITS*hpc1_rnd(D)-1:0] rnd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [D*NBITS-1:0]           out
);

  localparam int unsigned HPC1_RND = hpc1_rnd(D);

  logic en, xfer, ld1, ld2, ld3;
  logic v1_d, v2_d, v3_d, v1_q, v2_q, v3_q;

  assign en        = ~v3_q | out_ready;
  assign in_ready  = en & rnd_valid;
  assign xfer      = in_valid & in_ready;
  assign rnd_ready = xfer;
  assign ld1       = xfer;
  assign ld2       = en & v1_q;
  assign ld3       = en & v2_q;
  assign out_valid = v3_q;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    if (en) begin
      v1_d = in_valid & rnd_valid;
      v2_d = v1_q;
      v3_d = v2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  for (genvar l = 0; l < NBITS; l++) begin : g_lane
    msk_hpc1_lane #(
      .D      (D),
      .REF_SEL(REF_SEL)
    ) u_lane (
      .clk_i(clk),
      .rst_i(rst),
      .ld1_i(ld1),
      .ld2_i(ld2),
      .ld3_i(ld3),
      .a_i  (ina[share_lo(l, D) +: D]),
      .b_i  (inb[share_lo(l, D) +: D]),
      .rnd_i(rnd[rnd_lo(l, D) +: HPC1_RND]),
      .out_o(out[share_lo(l, D) +: D])
    );
  end

endmodule

// File: tb/tb_msk_and_hpc1_pipe.sv
// Directed bench: D=2 vector table on both refresh selections, plus D=3 x 4-lane
// streaming, back-pressure, randomness starvation and mid-flight reset sequences.
module tb_msk_and_hpc1_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_in_valid, a_rnd_valid, a_out_ready;
  logic [1:0] a_ina, a_inb, a_rnd;
  logic       a0_in_ready, a0_rnd_ready, a0_out_valid;
  logic [1:0] a0_out;
  logic       a2_in_ready, a2_rnd_ready, a2_out_valid;
  logic [1:0] a2_out;

  logic        b_in_valid, b_rnd_valid, b_out_ready;
  logic        b_in_ready, b_rnd_ready, b_out_valid;
  logic [11:0] b_ina, b_inb, b_out;
  logic [23:0] b_rnd;

  int checks = 0;
  int errors = 0;

  msk_and_hpc1_pipe #(.D(2), .NBITS(1), .REF_SEL(1'b0)) u_a0 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a0_in_ready),
    .ina(a_ina), .inb(a_inb), .rnd_valid(a_rnd_valid), .rnd_ready(a0_rnd_ready),
    .rnd(a_rnd), .out_valid(a0_out_valid), .out_ready(a_out_ready), .out(a0_out)
  );

  msk_and_hpc1_pipe #(.D(2), .NBITS(1), .REF_SEL(1'b1)) u_a2 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a2_in_ready),
    .ina(a_ina), .inb(a_inb), .rnd_valid(a_rnd_valid), .rnd_ready(a2_rnd_ready),
    .rnd(a_rnd), .out_valid(a2_out_valid), .out_ready(a_out_ready), .out(a2_out)
  );

  msk_and_hpc1_pipe #(.D(3), .NBITS(4), .REF_SEL(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ina(b_ina), .inb(b_inb), .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready),
    .rnd(b_rnd), .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out)
  );

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] r;
    logic       exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] unm3(input logic [11:0] x);
    logic [3:0] r;
    for (int l = 0; l < 4; l++) r[l] = ^x[l*3 +: 3];
    return r;
  endfunction

  // Streams n random ops into the D=3 instance; cycle c counts from the call.
  task automatic run_stream(input int n, input int stall_lo, input int stall_hi,
                            input int starve_lo, input int starve_hi,
                            output int first_x, output int first_o, output int gaps);
    logic [3:0]  q[$];
    logic [3:0]  e;
    logic [11:0] held, last_out;
    logic        held_ok, seen, stalled, starved;
    int          sent, got, c;
    sent = 0; got = 0; c = 0;
    held = '0; last_out = '0; held_ok = 1'b0; seen = 1'b0;
    first_x = -1; first_o = -1; gaps = 0;
    while (got < n && c < 400) begin
      stalled     = (c >= stall_lo) && (c <= stall_hi);
      starved     = (c >= starve_lo) && (c <= starve_hi);
      b_in_valid  = (sent < n);
      b_ina       = 12'($urandom);
      b_inb       = 12'($urandom);
      b_rnd       = 24'($urandom);
      b_out_ready = !stalled;
      b_rnd_valid = !starved;
      #1;
      chk("rnd_ready_eq_xfer", 32'(b_rnd_ready), 32'(b_in_valid & b_in_ready));
      if (starved) chk("starve_in_ready", 32'(b_in_ready), 0);
      if (!starved && !(b_out_valid && stalled)) chk("in_ready_high", 32'(b_in_ready), 1);
      if (b_in_valid && b_in_ready) begin
        q.push_back(unm3(b_ina) & unm3(b_inb));
        if (first_x < 0) first_x = c;
        sent++;
      end
      if (b_out_valid && stalled) begin
        chk("stall_in_ready", 32'(b_in_ready), 0);
        if (held_ok) chk("stall_out_hold", 32'(b_out), 32'(held));
        held = b_out;
        held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (!b_out_valid && seen) begin
        gaps++;
        chk("bubble_out_hold", 32'(b_out), 32'(last_out));
      end
      if (b_out_valid && b_out_ready) begin
        if (first_o < 0) first_o = c;
        if (q.size() == 0) begin
          chk("spurious_result", 1, 0);
        end else begin
          e = q.pop_front();
          chk("stream_and", 32'(unm3(b_out)), 32'(e));
        end
        got++;
        seen = 1'b1;
        last_out = b_out;
      end
      @(posedge clk); #1;
      c++;
    end
    b_in_valid = 1'b0;
    chk("stream_count", got, n);
  endtask

  initial begin
    vec_t vecs[8];
    int fx, fo, gaps;
    vecs[0] = '{a: 2'b01, b: 2'b10, r: 2'b11, exp: 1'b1};
    vecs[1] = '{a: 2'b01, b: 2'b11, r: 2'b11, exp: 1'b0};
    vecs[2] = '{a: 2'b11, b: 2'b01, r: 2'b00, exp: 1'b0};
    vecs[3] = '{a: 2'b10, b: 2'b10, r: 2'b01, exp: 1'b1};
    vecs[4] = '{a: 2'b00, b: 2'b11, r: 2'b10, exp: 1'b0};
    vecs[5] = '{a: 2'b11, b: 2'b11, r: 2'b00, exp: 1'b0};
    vecs[6] = '{a: 2'b10, b: 2'b01, r: 2'b10, exp: 1'b1};
    vecs[7] = '{a: 2'b01, b: 2'b01, r: 2'b00, exp: 1'b1};

    rst = 1'b1;
    a_in_valid = 1'b0; a_rnd_valid = 1'b1; a_out_ready = 1'b1;
    a_ina = '0; a_inb = '0; a_rnd = '0;
    b_in_valid = 1'b0; b_rnd_valid = 1'b1; b_out_ready = 1'b1;
    b_ina = '0; b_inb = '0; b_rnd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a0_out_valid", 32'(a0_out_valid), 0);
    chk("rst_a0_out", 32'(a0_out), 0);
    chk("rst_a2_out_valid", 32'(a2_out_valid), 0);
    chk("rst_b_out_valid", 32'(b_out_valid), 0);
    chk("rst_b_out", 32'(b_out), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_a0_in_ready", 32'(a0_in_ready), 1);
    chk("post_rst_b_in_ready", 32'(b_in_ready), 1);

    for (int v = 0; v < 8; v++) begin
      a_in_valid = 1'b1;
      a_ina = vecs[v].a;
      a_inb = vecs[v].b;
      a_rnd = vecs[v].r;
      #1;
      chk("tbl_rnd_ready_ref0", 32'(a0_rnd_ready), 1);
      chk("tbl_rnd_ready_ref1", 32'(a2_rnd_ready), 1);
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      @(posedge clk); #1;
      chk("tbl_early_valid", 32'(a0_out_valid), 0);
      @(posedge clk); #1;
      chk("tbl_valid_ref0", 32'(a0_out_valid), 1);
      chk("tbl_valid_ref1", 32'(a2_out_valid), 1);
      chk("tbl_and_ref0", 32'(^a0_out), 32'(vecs[v].exp));
      chk("tbl_and_ref1", 32'(^a2_out), 32'(vecs[v].exp));
    end

    run_stream(64, -1, -1, -1, -1, fx, fo, gaps);
    chk("stream_first_xfer", fx, 0);
    chk("stream_latency", fo - fx, 3);
    chk("stream_gaps", gaps, 0);

    run_stream(20, 4, 9, -1, -1, fx, fo, gaps);
    chk("bp_latency", fo - fx, 3);
    chk("bp_gaps", gaps, 0);

    run_stream(12, -1, -1, 2, 5, fx, fo, gaps);
    chk("starve_bubble_len", gaps, 4);

    b_out_ready = 1'b1;
    b_rnd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_in_valid = 1'b1;
      b_ina = 12'($urandom);
      b_inb = 12'($urandom);
      b_rnd = 24'($urandom);
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    #1;
    chk("inflight_valid", 32'(b_out_valid), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(b_out_valid), 0);
    chk("async_rst_out", 32'(b_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("no_stale_result", 32'(b_out_valid), 0);
      @(posedge clk); #1;
    end
    run_stream(1, -1, -1, -1, -1, fx, fo, gaps);
    chk("post_rst_latency", fo - fx, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
